// File: rtl/mmm_pkg.sv
// Shared machine-wide widths and the branch prediction queue entry format.
package mmm_pkg;

   localparam int XLEN = 32;
   localparam int HLEN = 10;

   // One in-flight prediction as captured from fetch.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [HLEN-1:0] index;
      logic [XLEN-1:0] target;
      logic            taken;
   } bpq_entry_t;

   // Fall-through address of a branch, wrapping modulo 2^XLEN.
   function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

endpackage

// File: rtl/branch_pred_queue_if.sv
// Fetch / execute / predictor-update signal bundle of the branch prediction queue.
// Handshake: a push transfers on a cycle where push_valid_i & push_ready_o are
// both high at the rising clock edge, and a resolve transfers on a cycle where
// ex_valid_i & ex_ready_o are both high. Readys never depend on the valids.
// res_valid_o / redirect_valid_o are single-cycle pulses with no back-pressure.
interface branch_pred_queue_if #(
   parameter int XLEN = mmm_pkg::XLEN,
   parameter int HLEN = mmm_pkg::HLEN
);
   logic            push_valid_i;
   logic            push_ready_o;
   logic [XLEN-1:0] push_pc_i;
   logic [HLEN-1:0] push_index_i;
   logic [XLEN-1:0] push_target_i;
   logic            push_taken_i;

   logic            ex_valid_i;
   logic            ex_ready_o;
   logic            ex_taken_i;
   logic [XLEN-1:0] ex_target_i;

   logic            res_valid_o;
   logic [XLEN-1:0] res_pc_o;
   logic [HLEN-1:0] res_index_o;
   logic [XLEN-1:0] res_target_o;
   logic            res_taken_o;
   logic            res_mispredict_o;

   logic            redirect_valid_o;
   logic [XLEN-1:0] redirect_pc_o;

   // Fetch/execute side: drives predictions and outcomes.
   modport master (
      output push_valid_i, push_pc_i, push_index_i, push_target_i, push_taken_i,
      output ex_valid_i, ex_taken_i, ex_target_i,
      input  push_ready_o, ex_ready_o,
      input  res_valid_o, res_pc_o, res_index_o, res_target_o, res_taken_o,
      input  res_mispredict_o, redirect_valid_o, redirect_pc_o
   );

   // Queue side.
   modport slave (
      input  push_valid_i, push_pc_i, push_index_i, push_target_i, push_taken_i,
      input  ex_valid_i, ex_taken_i, ex_target_i,
      output push_ready_o, ex_ready_o,
      output res_valid_o, res_pc_o, res_index_o, res_target_o, res_taken_o,
      output res_mispredict_o, redirect_valid_o, redirect_pc_o
   );
endinterface

// File: rtl/branch_pred_queue_fifo.sv
// Circular buffer of bpq_entry_t with push/pop/clear and occupancy count.
// Pointers are log2(DEPTH) bits and wrap naturally; DEPTH must be a power of 2.
// A push while full is refused even if a pop happens in the same cycle.
module bpq_fifo
   import mmm_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clear_i,
   input  logic          push_i,
   input  bpq_entry_t    wdata_i,
   input  logic          pop_i,
   output bpq_entry_t    rdata_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   bpq_entry_t    mem [DEPTH];
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          wr_en;
   logic          rd_en;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem[head_q];

   // Next pointer/count; clear dominates push and pop.
   always_comb begin
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (clear_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         wr_en = push_i & ~full_o;
         rd_en = pop_i & ~empty_o;
         if (wr_en) tail_d = tail_q + AW'(1);
         if (rd_en) head_d = head_q + AW'(1);
         count_d = count_q + CW'(wr_en) - CW'(rd_en);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage; contents are don't-care after reset so it has none.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem[tail_q] <= wdata_i;
   end

endmodule

// File: rtl/branch_pred_queue.sv
// Branch prediction queue: holds in-flight predictions in program order,
// compares each against the execute outcome, and drives the predictor update
// bus and the fetch redirect one cycle after an accepted resolve.
// XLEN/HLEN must match the package widths used by bpq_entry_t.
module branch_pred_queue
   import mmm_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int XLEN  = mmm_pkg::XLEN,
   parameter int HLEN  = mmm_pkg::HLEN
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   branch_pred_queue_if.slave       bus,
   output logic [$clog2(DEPTH):0]   count_o
);

   bpq_entry_t push_entry;
   bpq_entry_t head;
   logic       full;
   logic       empty;
   logic       resolve;
   logic       mispredict;
   logic       fifo_clear;
   logic       fifo_push;

   logic            res_valid_q, res_valid_d;
   logic [XLEN-1:0] res_pc_q, res_pc_d;
   logic [HLEN-1:0] res_index_q, res_index_d;
   logic [XLEN-1:0] res_target_q, res_target_d;
   logic            res_taken_q, res_taken_d;
   logic            res_mispredict_q, res_mispredict_d;
   logic            redirect_valid_q, redirect_valid_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

   assign push_entry.pc     = bus.push_pc_i;
   assign push_entry.index  = bus.push_index_i;
   assign push_entry.target = bus.push_target_i;
   assign push_entry.taken  = bus.push_taken_i;

   assign bus.push_ready_o = ~full;
   assign bus.ex_ready_o   = ~empty;

   // Resolve / mispredict decode; a mispredict makes every younger entry
   // wrong-path, so the queue is emptied and a same-cycle push is dropped.
   always_comb begin
      resolve    = bus.ex_valid_i & ~empty & ~flush_i;
      mispredict = (bus.ex_taken_i != head.taken) |
                   (bus.ex_taken_i & head.taken & (bus.ex_target_i != head.target));
      fifo_clear = flush_i | (resolve & mispredict);
      fifo_push  = bus.push_valid_i & ~flush_i;
   end

   bpq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (fifo_clear),
      .push_i  (fifo_push),
      .wdata_i (push_entry),
      .pop_i   (resolve),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count_o)
   );

   // Next update-bus and redirect values; all zero when nothing resolves.
   always_comb begin
      res_valid_d      = 1'b0;
      res_pc_d         = '0;
      res_index_d      = '0;
      res_target_d     = '0;
      res_taken_d      = 1'b0;
      res_mispredict_d = 1'b0;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = '0;
      if (resolve) begin
         res_valid_d      = 1'b1;
         res_pc_d         = head.pc;
         res_index_d      = head.index;
         res_target_d     = bus.ex_target_i;
         res_taken_d      = bus.ex_taken_i;
         res_mispredict_d = mispredict;
         if (mispredict) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = bus.ex_taken_i ? bus.ex_target_i : seq_pc(head.pc);
         end
      end
   end

   // Output registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         res_valid_q      <= 1'b0;
         res_pc_q         <= '0;
         res_index_q      <= '0;
         res_target_q     <= '0;
         res_taken_q      <= 1'b0;
         res_mispredict_q <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         res_valid_q      <= res_valid_d;
         res_pc_q         <= res_pc_d;
         res_index_q      <= res_index_d;
         res_target_q     <= res_target_d;
         res_taken_q      <= res_taken_d;
         res_mispredict_q <= res_mispredict_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
      end
   end

   assign bus.res_valid_o      = res_valid_q;
   assign bus.res_pc_o         = res_pc_q;
   assign bus.res_index_o      = res_index_q;
   assign bus.res_target_o     = res_target_q;
   assign bus.res_taken_o      = res_taken_q;
   assign bus.res_mispredict_o = res_mispredict_q;
   assign bus.redirect_valid_o = redirect_valid_q;
   assign bus.redirect_pc_o    = redirect_pc_q;

endmodule

// File: tb/tb_branch_pred_queue.sv
// Directed bench for branch_pred_queue (DEPTH=4, XLEN=32, HLEN=10).
module tb_branch_pred_queue;
   import mmm_pkg::*;

   logic       clk_i;
   logic       rst_i;
   logic       flush_i;
   logic [2:0] count_o;

   int n_pass;
   int n_total;

   logic [XLEN-1:0] exp_q[$];

   branch_pred_queue_if bus ();

   branch_pred_queue #(.DEPTH(4)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .bus     (bus),
      .count_o (count_o)
   );

   // Clock / reset
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance one cycle; inputs set before are sampled at the edge, outputs
   // are checked 1 time unit after it.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      bus.push_valid_i  = 1'b0;
      bus.push_pc_i     = '0;
      bus.push_index_i  = '0;
      bus.push_target_i = '0;
      bus.push_taken_i  = 1'b0;
      bus.ex_valid_i    = 1'b0;
      bus.ex_taken_i    = 1'b0;
      bus.ex_target_i   = '0;
      flush_i           = 1'b0;
   endtask

   task automatic set_push(input logic [XLEN-1:0] pc, input logic [HLEN-1:0] idx,
                           input logic [XLEN-1:0] tgt, input logic tkn);
      bus.push_valid_i  = 1'b1;
      bus.push_pc_i     = pc;
      bus.push_index_i  = idx;
      bus.push_target_i = tgt;
      bus.push_taken_i  = tkn;
   endtask

   task automatic set_ex(input logic tkn, input logic [XLEN-1:0] tgt);
      bus.ex_valid_i  = 1'b1;
      bus.ex_taken_i  = tkn;
      bus.ex_target_i = tgt;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      idle();
      rst_i = 1'b1;
      step();
      step();
      rst_i = 1'b0;

      // Reset state
      chk("rst_count", 64'(count_o), 64'd0);
      chk("rst_push_ready", 64'(bus.push_ready_o), 64'd1);
      chk("rst_ex_ready", 64'(bus.ex_ready_o), 64'd0);
      chk("rst_res_valid", 64'(bus.res_valid_o), 64'd0);
      chk("rst_redirect_valid", 64'(bus.redirect_valid_o), 64'd0);

      // Correct taken prediction
      set_push(32'h100, 10'h011, 32'h200, 1'b1);
      step();
      idle();
      chk("t2_count_after_push", 64'(count_o), 64'd1);
      chk("t2_ex_ready", 64'(bus.ex_ready_o), 64'd1);
      set_ex(1'b1, 32'h200);
      step();
      idle();
      chk("t2_res_valid", 64'(bus.res_valid_o), 64'd1);
      chk("t2_res_pc", 64'(bus.res_pc_o), 64'h100);
      chk("t2_res_index", 64'(bus.res_index_o), 64'h011);
      chk("t2_res_target", 64'(bus.res_target_o), 64'h200);
      chk("t2_mispredict", 64'(bus.res_mispredict_o), 64'd0);
      chk("t2_redirect_valid", 64'(bus.redirect_valid_o), 64'd0);
      chk("t2_count", 64'(count_o), 64'd0);
      step();
      chk("t2_res_valid_pulse", 64'(bus.res_valid_o), 64'd0);

      // Direction mispredict, younger entry discarded
      set_push(32'h100, 10'h011, 32'h200, 1'b1);
      step();
      set_push(32'h204, 10'h022, 32'h0, 1'b0);
      step();
      idle();
      chk("t3_count_two", 64'(count_o), 64'd2);
      set_ex(1'b0, 32'h0);
      step();
      idle();
      chk("t3_res_valid", 64'(bus.res_valid_o), 64'd1);
      chk("t3_mispredict", 64'(bus.res_mispredict_o), 64'd1);
      chk("t3_res_taken", 64'(bus.res_taken_o), 64'd0);
      chk("t3_redirect_valid", 64'(bus.redirect_valid_o), 64'd1);
      chk("t3_redirect_pc", 64'(bus.redirect_pc_o), 64'h104);
      chk("t3_count", 64'(count_o), 64'd0);
      chk("t3_ex_ready", 64'(bus.ex_ready_o), 64'd0);
      step();
      chk("t3_redirect_pulse", 64'(bus.redirect_valid_o), 64'd0);

      // Target mispredict
      set_push(32'h400, 10'h033, 32'h200, 1'b1);
      step();
      idle();
      set_ex(1'b1, 32'h300);
      step();
      idle();
      chk("t4_mispredict", 64'(bus.res_mispredict_o), 64'd1);
      chk("t4_res_target", 64'(bus.res_target_o), 64'h300);
      chk("t4_redirect_valid", 64'(bus.redirect_valid_o), 64'd1);
      chk("t4_redirect_pc", 64'(bus.redirect_pc_o), 64'h300);
      chk("t4_count", 64'(count_o), 64'd0);

      // Fill to DEPTH, then full push with a simultaneous resolve
      for (int i = 0; i < 4; i++) begin
         set_push(32'h10 * (i + 1), 10'(i), 32'h0, 1'b0);
         exp_q.push_back(32'h10 * (i + 1));
         step();
      end
      idle();
      chk("t5_count_full", 64'(count_o), 64'd4);
      chk("t5_push_ready_full", 64'(bus.push_ready_o), 64'd0);
      set_push(32'h50, 10'h005, 32'h0, 1'b0);
      set_ex(1'b0, 32'h0);
      step();
      idle();
      chk("t5_full_res_pc", 64'(bus.res_pc_o), 64'(exp_q.pop_front()));
      chk("t5_full_mispredict", 64'(bus.res_mispredict_o), 64'd0);
      chk("t5_count_after_reject", 64'(count_o), 64'd3);
      chk("t5_push_ready", 64'(bus.push_ready_o), 64'd1);

      // Steady push + resolve at count 3; pointers wrap several times
      for (int i = 0; i < 10; i++) begin
         set_push(32'h60 + 32'h10 * i, 10'(i + 6), 32'h0, 1'b0);
         set_ex(1'b0, 32'h0);
         exp_q.push_back(32'h60 + 32'h10 * i);
         step();
         chk("t5_wrap_res_valid", 64'(bus.res_valid_o), 64'd1);
         chk("t5_wrap_res_pc", 64'(bus.res_pc_o), 64'(exp_q.pop_front()));
         chk("t5_wrap_count", 64'(count_o), 64'd3);
      end
      idle();

      // Flush beats a mispredicting resolve and a push
      flush_i = 1'b1;
      set_ex(1'b1, 32'h999);
      set_push(32'hAAA, 10'h0AA, 32'h0, 1'b0);
      step();
      idle();
      exp_q.delete();
      chk("t6_res_valid", 64'(bus.res_valid_o), 64'd0);
      chk("t6_redirect_valid", 64'(bus.redirect_valid_o), 64'd0);
      chk("t6_count", 64'(count_o), 64'd0);

      // Resolve on an empty queue is ignored
      set_ex(1'b1, 32'h123);
      step();
      idle();
      chk("t6_empty_res_valid", 64'(bus.res_valid_o), 64'd0);
      chk("t6_empty_redirect", 64'(bus.redirect_valid_o), 64'd0);
      chk("t6_empty_count", 64'(count_o), 64'd0);

      // Asynchronous reset mid-operation with 3 entries queued
      for (int i = 0; i < 4; i++) begin
         set_push(32'h1000 + 32'h4 * i, 10'(i), 32'h0, 1'b0);
         step();
      end
      idle();
      set_ex(1'b0, 32'h0);
      step();
      idle();
      chk("t1_pre_count", 64'(count_o), 64'd3);
      chk("t1_pre_res_valid", 64'(bus.res_valid_o), 64'd1);
      #2;
      rst_i = 1'b1;
      #1;
      chk("t1_count", 64'(count_o), 64'd0);
      chk("t1_push_ready", 64'(bus.push_ready_o), 64'd1);
      chk("t1_ex_ready", 64'(bus.ex_ready_o), 64'd0);
      chk("t1_res_valid", 64'(bus.res_valid_o), 64'd0);
      chk("t1_res_pc", 64'(bus.res_pc_o), 64'd0);
      step();
      rst_i = 1'b0;
      step();
      chk("t1_post_count", 64'(count_o), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
